// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch key front-end: per-key sync/debounce/press detect feeding a RUN/PAUSE/IDLE FSM.
// Optional: define KEY_CLR_IN_RUN_EN to let the clear key stop and zero the watch from RUN.

module stopwatch_key_debounce #(
    parameter logic [19:0] CNT_20MS = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic press
);
    logic [1:0]  sync;
    logic        key_sync;
    logic [19:0] cnt;

    assign key_sync = sync[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync <= 2'b11;
        else            sync <= {sync[0], key_n};
    end

    // Count saturates at CNT_20MS so a held key never re-fires.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)          cnt <= '0;
        else if (key_sync)       cnt <= '0;
        else if (cnt < CNT_20MS) cnt <= cnt + 20'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) press <= 1'b0;
        else            press <= (cnt == CNT_20MS - 20'd1) && !key_sync;
    end
endmodule

module stopwatch_key_ctrl #(
    parameter logic [19:0] CNT_20MS = 20'd999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    output logic       start_signal,
    output logic       clear_signal,
    output logic [1:0] state
);
    localparam int NUM_KEYS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        PAUSE   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] press;
    logic                sp;
    logic                cp;
    state_t              state_q;
    state_t              state_nxt;
    logic                clr_nxt;

    assign key_n = {key_clear_n, key_start_n};
    assign sp    = press[0];
    assign cp    = press[1];

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
            stopwatch_key_debounce #(.CNT_20MS(CNT_20MS)) u_db (
                .sys_clk   (sys_clk),
                .sys_rst_n (sys_rst_n),
                .key_n     (key_n[k]),
                .press     (press[k])
            );
        end
    endgenerate

    // Clear has priority over start except in RUN (unless clear-in-run is enabled).
    always_comb begin
        state_nxt = state_q;
        clr_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cp)      clr_nxt   = 1'b1;
                else if (sp) state_nxt = RUN;
            end
            RUN: begin
`ifdef KEY_CLR_IN_RUN_EN
                if (cp) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end else if (sp) begin
                    state_nxt = PAUSE;
                end
`else
                if (sp) state_nxt = PAUSE;
`endif
            end
            PAUSE: begin
                if (cp) begin
                    state_nxt = IDLE;
                    clr_nxt   = 1'b1;
                end else if (sp) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            start_signal <= 1'b0;
            clear_signal <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            start_signal <= (state_nxt == RUN);
            clear_signal <= clr_nxt;
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Directed bench for stopwatch_key_ctrl with CNT_20MS = 10 (press lands 13 edges after key drop).
// Honours KEY_CLR_IN_RUN_EN the same way the design does.

module tb_stopwatch_key_ctrl;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_start_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic       start_signal;
    logic       clear_signal;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;
    int clr_pulses = 0;
    int clr_long = 0;
    int start_hi = 0;
    logic clr_prev = 1'b0;
    int p0, s0;

    stopwatch_key_ctrl #(.CNT_20MS(20'd10)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .key_start_n  (key_start_n),
        .key_clear_n  (key_clear_n),
        .start_signal (start_signal),
        .clear_signal (clear_signal),
        .state        (state)
    );

    always #10 sys_clk = ~sys_clk;

    // Cumulative output activity, sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (clear_signal) begin
            if (clr_prev) clr_long++;
            else          clr_pulses++;
        end
        if (start_signal) start_hi++;
        clr_prev = clear_signal;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst_n   = 1'b0;
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        tick(2);
        sys_rst_n = 1'b1;
        tick(2);
    endtask

    task automatic hold_keys(input logic s, input logic c, input int hold, input int gap);
        key_start_n = !s;
        key_clear_n = !c;
        tick(hold);
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        tick(gap);
    endtask

    initial begin
        // 1: reset with random keys
        #1;
        key_start_n = 1'($urandom);
        key_clear_n = 1'($urandom);
        tick(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_start", 32'(start_signal), 32'd0);
        check("rst_clear", 32'(clear_signal), 32'd0);
        sys_rst_n = 1'b1;
        tick(3);
        check("rel_state", 32'(state), 32'd0);
        check("rel_start", 32'(start_signal), 32'd0);
        check("rel_clear", 32'(clear_signal), 32'd0);
        key_start_n = 1'b1;
        key_clear_n = 1'b1;
        tick(5);

        // 3: bouncing start key, 3 low / 3 high, never reaches the count
        s0 = start_hi;
        for (int i = 0; i < 30; i++) begin
            key_start_n = ((i / 3) % 2) != 0;
            tick(1);
        end
        key_start_n = 1'b1;
        tick(20);
        check("bounce_state", 32'(state), 32'd0);
        check("bounce_start", 32'(start_hi - s0), 32'd0);

        // debounce boundary: 9 cycles low is one short
        hold_keys(1'b1, 1'b0, 9, 20);
        check("short9_state", 32'(state), 32'd0);

        // 2: start held 40 cycles, output exactly at edge 13
        key_start_n = 1'b0;
        tick(12);
        check("e12_start", 32'(start_signal), 32'd0);
        check("e12_state", 32'(state), 32'd0);
        tick(1);
        check("e13_start", 32'(start_signal), 32'd1);
        check("e13_state", 32'(state), 32'd1);
        tick(27);
        check("held_state", 32'(state), 32'd1);
        key_start_n = 1'b1;
        tick(20);
        check("released_state", 32'(state), 32'd1);
        check("released_start", 32'(start_signal), 32'd1);

        // debounce boundary: exactly 10 cycles low is enough
        do_reset();
        hold_keys(1'b1, 1'b0, 10, 20);
        check("exact10_state", 32'(state), 32'd1);

        // 4: start, start, clear
        do_reset();
        p0 = clr_pulses;
        hold_keys(1'b1, 1'b0, 15, 20);
        check("seq_run", 32'(state), 32'd1);
        hold_keys(1'b1, 1'b0, 15, 20);
        check("seq_pause", 32'(state), 32'd2);
        check("seq_pause_start", 32'(start_signal), 32'd0);
        hold_keys(1'b0, 1'b1, 15, 20);
        check("seq_idle", 32'(state), 32'd0);
        check("seq_clr_pulses", 32'(clr_pulses - p0), 32'd1);
        check("seq_clr_long", 32'(clr_long), 32'd0);

        // 5: clear while running
        do_reset();
        hold_keys(1'b1, 1'b0, 15, 20);
        check("run5_state", 32'(state), 32'd1);
        p0 = clr_pulses;
        hold_keys(1'b0, 1'b1, 15, 20);
`ifdef KEY_CLR_IN_RUN_EN
        check("clr_in_run_state", 32'(state), 32'd0);
        check("clr_in_run_start", 32'(start_signal), 32'd0);
        check("clr_in_run_pulses", 32'(clr_pulses - p0), 32'd1);
`else
        check("clr_in_run_state", 32'(state), 32'd1);
        check("clr_in_run_start", 32'(start_signal), 32'd1);
        check("clr_in_run_pulses", 32'(clr_pulses - p0), 32'd0);
`endif

        // simultaneous start & clear in RUN
        do_reset();
        hold_keys(1'b1, 1'b0, 15, 20);
        p0 = clr_pulses;
        hold_keys(1'b1, 1'b1, 15, 20);
`ifdef KEY_CLR_IN_RUN_EN
        check("both_run_state", 32'(state), 32'd0);
        check("both_run_pulses", 32'(clr_pulses - p0), 32'd1);
`else
        check("both_run_state", 32'(state), 32'd2);
        check("both_run_pulses", 32'(clr_pulses - p0), 32'd0);
`endif

        // 6: simultaneous start & clear in PAUSE
        do_reset();
        hold_keys(1'b1, 1'b0, 15, 20);
        hold_keys(1'b1, 1'b0, 15, 20);
        check("pause6_state", 32'(state), 32'd2);
        p0 = clr_pulses;
        s0 = start_hi;
        hold_keys(1'b1, 1'b1, 15, 20);
        check("both_pause_state", 32'(state), 32'd0);
        check("both_pause_pulses", 32'(clr_pulses - p0), 32'd1);
        check("both_pause_start", 32'(start_hi - s0), 32'd0);
        check("clr_never_long", 32'(clr_long), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
